// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe : pipeline control unit for the RV64 core.
//
// Merges per-stage hold requests, branch/jump redirects and trap redirects into
// per-stage stall/flush vectors and a single PC redirect. Redirects that cannot
// be taken because downstream is held are parked (pending) until the hold
// clears. Each accepted redirect opens a FLUSH_CYCLES fetch-kill window on
// stage 0. Traps win over both a live jump and a pending jump.
//
// Optional feature: define CTRL_PERF_EN to add the stall_cyc_o and
// redirect_cnt_o performance counters.
//
// Ports:
//   clk            in   core clock
//   rst            in   asynchronous active-low reset
//   jump_en_i      in   branch/jump taken from JUMP_STAGE
//   jump_addr_i    in   jump target (XLEN)
//   trap_en_i      in   trap redirect from JUMP_STAGE
//   trap_addr_i    in   trap vector (XLEN)
//   hold_req_i     in   bit k = stage k cannot advance (NSTAGE)
//   jump_en_o      out  PC redirect strobe
//   jump_addr_o    out  redirect target, 0 when no redirect (XLEN)
//   stall_o        out  bit k = stage k register holds (NSTAGE)
//   flush_o        out  bit k = stage k register loads a bubble (NSTAGE)
//   stall_cyc_o    out  [CTRL_PERF_EN] cycles with any stall (32)
//   redirect_cnt_o out  [CTRL_PERF_EN] accepted redirects (32)
//   busy_o         out  redirect pending or kill window active
// -----------------------------------------------------------------------------
module ctrl_pipe #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned NSTAGE       = 5,
   parameter int unsigned JUMP_STAGE   = 2,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en_i,
   input  logic [XLEN-1:0]   jump_addr_i,
   input  logic              trap_en_i,
   input  logic [XLEN-1:0]   trap_addr_i,
   input  logic [NSTAGE-1:0] hold_req_i,
   output logic              jump_en_o,
   output logic [XLEN-1:0]   jump_addr_o,
   output logic [NSTAGE-1:0] stall_o,
   output logic [NSTAGE-1:0] flush_o,
`ifdef CTRL_PERF_EN
   output logic [31:0]       stall_cyc_o,
   output logic [31:0]       redirect_cnt_o,
`endif
   output logic              busy_o
);

   localparam int unsigned KW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [KW-1:0] KILL_LOAD = KW'(FLUSH_CYCLES);

   logic              r_pend_vld;
   logic [XLEN-1:0]   r_pend_addr;
   logic [KW-1:0]     r_kill_cnt;

   logic [NSTAGE-1:0] w_hold_ge;   // bit k = some hold at index >= k
   logic              w_req;
   logic              w_accept;
   logic              w_kill_act;
   logic [XLEN-1:0]   w_sel_addr;
   logic [NSTAGE-1:0] w_stall;
   logic [NSTAGE-1:0] w_flush;

   // Suffix-OR of the hold vector: stage k stalls iff anything at or above it holds.
   always_comb begin
      logic [NSTAGE-1:0] v_ge;
      v_ge = '0;
      v_ge[NSTAGE-1] = hold_req_i[NSTAGE-1];
      for (int k = int'(NSTAGE) - 2; k >= 0; k--) begin
         v_ge[k] = hold_req_i[k] | v_ge[k+1];
      end
      w_hold_ge = v_ge;
   end

   // Pending jump blocks new jumps; trap overrides everything.
   assign w_req      = trap_en_i | jump_en_i | r_pend_vld;
   assign w_sel_addr = trap_en_i  ? trap_addr_i :
                       r_pend_vld ? r_pend_addr : jump_addr_i;
   assign w_accept   = w_req & ~w_hold_ge[JUMP_STAGE+1];
   assign w_kill_act = (r_kill_cnt != '0);

   always_comb begin
      w_stall = w_hold_ge;
      w_flush = '0;
      // Bubble goes into the stage directly behind the highest holding stage.
      for (int k = 1; k < int'(NSTAGE); k++) begin
         w_flush[k] = w_hold_ge[k-1] & ~w_hold_ge[k];
      end
      if (w_kill_act) begin
         w_flush[0] = 1'b1;
         w_stall[0] = 1'b0;
      end
      // Accepted redirect squashes everything up to the resolving stage.
      if (w_accept) begin
         for (int k = 0; k <= int'(JUMP_STAGE); k++) begin
            w_flush[k] = 1'b1;
            w_stall[k] = 1'b0;
         end
      end
   end

   // Outputs are forced quiet while reset is asserted, independent of inputs.
   assign jump_en_o   = rst & w_accept;
   assign jump_addr_o = (rst & w_accept) ? w_sel_addr : '0;
   assign stall_o     = rst ? w_stall : '0;
   assign flush_o     = rst ? w_flush : '0;
   assign busy_o      = rst & (r_pend_vld | w_kill_act);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend_vld  <= 1'b0;
         r_pend_addr <= '0;
         r_kill_cnt  <= '0;
      end else if (w_accept) begin
         r_pend_vld <= 1'b0;
         r_kill_cnt <= KILL_LOAD;
      end else begin
         if (w_req) begin
            r_pend_vld  <= 1'b1;
            r_pend_addr <= w_sel_addr;
         end
         if (w_kill_act) begin
            r_kill_cnt <= r_kill_cnt - KW'(1);
         end
      end
   end

`ifdef CTRL_PERF_EN
   logic [31:0] r_stall_cyc;
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cyc    <= '0;
         r_redirect_cnt <= '0;
      end else begin
         if (stall_o != '0) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
         end
         if (jump_en_o) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         end
      end
   end

   assign stall_cyc_o    = r_stall_cyc;
   assign redirect_cnt_o = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe : self-checking bench for ctrl_pipe (default parameters).
// Hand-written vector table for the directed scenarios, explicit reset
// sequences, then randomized stimulus against a behavioural model.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;

   localparam int NS = 5;
   localparam int JS = 2;
   localparam int FC = 2;

   typedef struct {
      logic        je;
      logic [63:0] ja;
      logic        te;
      logic [63:0] ta;
      logic [4:0]  hold;
      logic        ejen;
      logic [63:0] eaddr;
      logic [4:0]  estall;
      logic [4:0]  eflush;
      logic        ebusy;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        jump_en_i;
   logic [63:0] jump_addr_i;
   logic        trap_en_i;
   logic [63:0] trap_addr_i;
   logic [4:0]  hold_req_i;
   logic        jump_en_o;
   logic [63:0] jump_addr_o;
   logic [4:0]  stall_o;
   logic [4:0]  flush_o;
   logic        busy_o;
`ifdef CTRL_PERF_EN
   logic [31:0] stall_cyc_o;
   logic [31:0] redirect_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   // Behavioural model state
   logic        m_pend = 1'b0;
   logic [63:0] m_paddr = '0;
   int          m_kill = 0;
   logic        n_pend;
   logic [63:0] n_paddr;
   int          n_kill;

   ctrl_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .jump_en_i   (jump_en_i),
      .jump_addr_i (jump_addr_i),
      .trap_en_i   (trap_en_i),
      .trap_addr_i (trap_addr_i),
      .hold_req_i  (hold_req_i),
      .jump_en_o   (jump_en_o),
      .jump_addr_o (jump_addr_o),
      .stall_o     (stall_o),
      .flush_o     (flush_o),
`ifdef CTRL_PERF_EN
      .stall_cyc_o    (stall_cyc_o),
      .redirect_cnt_o (redirect_cnt_o),
`endif
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic je, input logic [63:0] ja, input logic te,
                      input logic [63:0] ta, input logic [4:0] hold, input logic ejen,
                      input logic [63:0] eaddr, input logic [4:0] estall,
                      input logic [4:0] eflush, input logic ebusy);
      vec_t v;
      v.je = je; v.ja = ja; v.te = te; v.ta = ta; v.hold = hold;
      v.ejen = ejen; v.eaddr = eaddr; v.estall = estall; v.eflush = eflush; v.ebusy = ebusy;
      vecs.push_back(v);
   endtask

   task automatic check_outs(input string tag, input vec_t v);
      check({tag, " jump_en_o"},   {63'd0, jump_en_o}, {63'd0, v.ejen});
      check({tag, " jump_addr_o"}, jump_addr_o,        v.eaddr);
      check({tag, " stall_o"},     {59'd0, stall_o},   {59'd0, v.estall});
      check({tag, " flush_o"},     {59'd0, flush_o},   {59'd0, v.eflush});
      check({tag, " busy_o"},      {63'd0, busy_o},    {63'd0, v.ebusy});
   endtask

   // Drive at posedge+1, sample mid-cycle, then step to the next posedge+1.
   task automatic run_vec(input string tag, input vec_t v);
      jump_en_i   = v.je;
      jump_addr_i = v.ja;
      trap_en_i   = v.te;
      trap_addr_i = v.ta;
      hold_req_i  = v.hold;
      #3;
      check_outs(tag, v);
      @(posedge clk);
      #1;
   endtask

   // Expected outputs and next state derived directly from the rules.
   task automatic model(inout vec_t v);
      int          h;
      logic        req;
      logic        acc;
      logic [63:0] sel;
      h = -1;
      for (int k = 0; k < NS; k++) if (v.hold[k]) h = k;
      v.estall = '0;
      v.eflush = '0;
      for (int j = 0; j < NS; j++) if (j <= h) v.estall[j] = 1'b1;
      if (h >= 0 && h + 1 < NS) v.eflush[h+1] = 1'b1;
      req = v.te || v.je || m_pend;
      sel = v.te ? v.ta : (m_pend ? m_paddr : v.ja);
      acc = req && (h <= JS);
      if (m_kill > 0) begin
         v.eflush[0] = 1'b1;
         v.estall[0] = 1'b0;
      end
      v.ejen  = acc;
      v.eaddr = acc ? sel : 64'd0;
      if (acc) begin
         for (int j = 0; j <= JS; j++) begin
            v.eflush[j] = 1'b1;
            v.estall[j] = 1'b0;
         end
      end
      v.ebusy = m_pend || (m_kill != 0);
      n_pend  = m_pend;
      n_paddr = m_paddr;
      n_kill  = m_kill;
      if (acc) begin
         n_pend = 1'b0;
         n_kill = FC;
      end else begin
         if (req) begin
            n_pend  = 1'b1;
            n_paddr = sel;
         end
         if (m_kill > 0) n_kill = m_kill - 1;
      end
   endtask

   localparam logic [63:0] Z  = 64'd0;
   localparam logic [63:0] A1 = 64'h0000_0000_8000_0100;
   localparam logic [63:0] A2 = 64'h0000_0000_8000_0200;
   localparam logic [63:0] A3 = 64'h0000_0000_8000_0300;
   localparam logic [63:0] AT = 64'h0000_0000_8000_0004;
   localparam logic [63:0] A4 = 64'h0000_0000_8000_0400;
   localparam logic [63:0] A5 = 64'h0000_0000_8000_0500;

   initial begin
      vec_t v;
      // je  ja  te  ta  hold      ejen eaddr stall     flush     busy
      add(1, A1, 0, Z, 5'b00000, 1, A1, 5'b00000, 5'b00111, 0);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);
      add(0, Z,  0, Z, 5'b00100, 0, Z,  5'b00111, 5'b01000, 0);
      add(0, Z,  0, Z, 5'b00100, 0, Z,  5'b00111, 5'b01000, 0);
      add(0, Z,  0, Z, 5'b00100, 0, Z,  5'b00111, 5'b01000, 0);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);
      // jump parked behind a downstream hold
      add(1, A2, 0, Z, 5'b01000, 0, Z,  5'b01111, 5'b10000, 0);
      add(0, Z,  0, Z, 5'b01000, 0, Z,  5'b01111, 5'b10000, 1);
      add(0, Z,  0, Z, 5'b00000, 1, A2, 5'b00000, 5'b00111, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);
      // trap overrides a pending jump; a new jump is ignored while pending
      add(1, A2, 0, Z,  5'b01000, 0, Z,  5'b01111, 5'b10000, 0);
      add(1, A3, 1, AT, 5'b01000, 0, Z,  5'b01111, 5'b10000, 1);
      add(0, Z,  0, Z,  5'b01000, 0, Z,  5'b01111, 5'b10000, 1);
      add(0, Z,  0, Z,  5'b00000, 1, AT, 5'b00000, 5'b00111, 1);
      // second jump at kill_cnt=1 restarts the window
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(1, A4, 0, Z, 5'b00000, 1, A4, 5'b00000, 5'b00111, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);
      // accept with a hold at or below the jump stage: flush wins
      add(1, A5, 0, Z, 5'b00010, 1, A5, 5'b00000, 5'b00111, 0);
      add(0, Z,  0, Z, 5'b00001, 0, Z,  5'b00000, 5'b00011, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00001, 1);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);
      // hold at the last stage: everything stalls, no bubble slot
      add(0, Z,  0, Z, 5'b10000, 0, Z,  5'b11111, 5'b00000, 0);
      add(0, Z,  0, Z, 5'b00000, 0, Z,  5'b00000, 5'b00000, 0);

      // Reset with random inputs: everything quiet
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v.je = 1'($urandom); v.ja = {$urandom, $urandom};
         v.te = 1'($urandom); v.ta = {$urandom, $urandom};
         v.hold = 5'($urandom);
         v.ejen = 0; v.eaddr = Z; v.estall = '0; v.eflush = '0; v.ebusy = 0;
         run_vec($sformatf("reset[%0d]", i), v);
      end
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec($sformatf("vec[%0d]", i), vecs[i]);
      end

      // Reset mid kill window
      v.je = 1; v.ja = A1; v.te = 0; v.ta = Z; v.hold = '0;
      v.ejen = 1; v.eaddr = A1; v.estall = '0; v.eflush = 5'b00111; v.ebusy = 0;
      run_vec("rstwin accept", v);
      jump_en_i = 0; jump_addr_i = Z; hold_req_i = 5'b00001;
      #1 rst = 1'b0;
      #1;
      v.je = 0; v.ja = Z; v.hold = 5'b00001;
      v.ejen = 0; v.eaddr = Z; v.estall = '0; v.eflush = '0; v.ebusy = 0;
      check_outs("rstwin async", v);
      @(posedge clk);
      #1 rst = 1'b1;
      v.hold = '0;
      run_vec("rstwin after", v);

      // Reset while a jump is pending
      v.je = 1; v.ja = A2; v.hold = 5'b01000;
      v.ejen = 0; v.eaddr = Z; v.estall = 5'b01111; v.eflush = 5'b10000; v.ebusy = 0;
      run_vec("rstpend park", v);
      jump_en_i = 0; jump_addr_i = Z;
      #1 rst = 1'b0;
      #1;
      v.je = 0; v.ja = Z;
      v.ejen = 0; v.eaddr = Z; v.estall = '0; v.eflush = '0; v.ebusy = 0;
      check_outs("rstpend async", v);
      @(posedge clk);
      #1 rst = 1'b1;
      v.hold = '0;
      run_vec("rstpend after0", v);
      run_vec("rstpend after1", v);

      // Randomized against the model (DUT state is idle here)
      m_pend = 1'b0; m_paddr = '0; m_kill = 0;
      for (int i = 0; i < 500; i++) begin
         v.je = ($urandom_range(0, 9) < 3);
         v.ja = {$urandom, $urandom};
         v.te = ($urandom_range(0, 9) == 0);
         v.ta = {$urandom, $urandom};
         for (int k = 0; k < NS; k++) v.hold[k] = ($urandom_range(0, 5) == 0);
         model(v);
         run_vec($sformatf("rand[%0d]", i), v);
         m_pend = n_pend; m_paddr = n_paddr; m_kill = n_kill;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
